param_step_acc: RTL and testbench

Multi-channel parametrised step accumulator, the sequential successor to the team's fixed-width, parameter-increment adder blocks. Each channel holds a WIDTH-bit accumulator. An accumulator is stepped by a signed integer parameter, stepped by a runtime argument, loaded, or cleared. Results come back through a registered valid/ready response slot with per-operation and sticky overflow reporting. The block sits in the parameter-handling regression designs and exercises signed/unsigned width rules under real state.

---
 rtl/param_step_acc.sv | 169 ++++++++++++++++
 tb/tb_param_step_acc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_step_acc.sv
// ============================================================================
// Module  : param_step_acc
// Brief   : Multi-channel step accumulator with registered valid/ready
//           response slot, per-op and sticky overflow reporting.
//           Build option: PARAM_STEP_ACC_SAT_EN (saturate instead of wrap).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module param_step_acc #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int INC      = 1,
  parameter int SIGNED   = 0,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CW-1:0]             cmd_chan,
  input  logic [1:0]                cmd_op,
  input  logic [WIDTH-1:0]          cmd_arg,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [CW-1:0]             rsp_chan,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_ovf,
  output logic                      rsp_err,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       ovf_sticky,
  input  logic [CHANNELS-1:0]       clr_sticky
);

  localparam int               c_ew       = WIDTH + 2;
  localparam logic [0:0]       c_st_empty = 1'b0;
  localparam logic [0:0]       c_st_full  = 1'b1;
  localparam logic [CW:0]      c_nch      = (CW+1)'(CHANNELS);
  localparam logic [WIDTH-1:0] c_inc      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] c_max      = (SIGNED != 0) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                          : {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_min      = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                          : {WIDTH{1'b0}};

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             w_accept;
  logic             w_chan_ok;
  logic [WIDTH-1:0] w_acc_cur;
  logic [WIDTH-1:0] w_step;
  logic [c_ew-1:0]  w_acc_ext;
  logic [c_ew-1:0]  w_step_ext;
  logic [c_ew-1:0]  w_sum;
  logic             w_sum_ovf;
  logic             w_ovf;
  logic [WIDTH-1:0] w_step_res;
  logic [WIDTH-1:0] w_res;
  logic [CW-1:0]    r_rsp_chan;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_ovf;
  logic             r_rsp_err;

  // Response slot FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_empty;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_empty: if (w_accept) w_state_nxt = c_st_full;
      c_st_full:  if (rsp_ready && !w_accept) w_state_nxt = c_st_empty;
      default:    w_state_nxt = c_st_empty;
    endcase
  end

  always_comb begin
    rsp_valid = (r_state == c_st_full);
    cmd_ready = (r_state == c_st_empty) || rsp_ready;
    w_accept  = cmd_valid && cmd_ready;
  end

  assign w_chan_ok = ({1'b0, cmd_chan} < c_nch);

  // Out-of-range channels read as zero so the datapath never indexes past the array
  always_comb begin
    w_acc_cur = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cmd_chan == CW'(k)) w_acc_cur = count[k*WIDTH +: WIDTH];
    end
  end

  assign w_step     = (cmd_op == 2'b00) ? c_inc : cmd_arg;
  assign w_acc_ext  = (SIGNED != 0) ? {{2{w_acc_cur[WIDTH-1]}}, w_acc_cur}
                                    : {2'b00, w_acc_cur};
  assign w_step_ext = {{2{w_step[WIDTH-1]}}, w_step};
  assign w_sum      = w_acc_ext + w_step_ext;

  // Exact sum fits in WIDTH+2 signed bits; overflow when the guard bits disagree with the range
  always_comb begin
    if (SIGNED != 0)
      w_sum_ovf = !((&w_sum[c_ew-1:WIDTH-1]) || !(|w_sum[c_ew-1:WIDTH-1]));
    else
      w_sum_ovf = |w_sum[c_ew-1:WIDTH];
  end

  assign w_ovf = w_sum_ovf && !cmd_op[1] && w_chan_ok;

  always_comb begin
    w_step_res = w_sum[WIDTH-1:0];
`ifdef PARAM_STEP_ACC_SAT_EN
    if (w_sum_ovf) w_step_res = w_sum[c_ew-1] ? c_min : c_max;
`endif
  end

  always_comb begin
    case (cmd_op)
      2'b10:   w_res = cmd_arg;
      2'b11:   w_res = '0;
      default: w_res = w_step_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_chan <= '0;
      r_rsp_data <= '0;
      r_rsp_ovf  <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_rsp_chan <= cmd_chan;
      r_rsp_data <= w_chan_ok ? w_res : '0;
      r_rsp_ovf  <= w_ovf;
      r_rsp_err  <= !w_chan_ok;
    end
  end

  assign rsp_chan = r_rsp_chan;
  assign rsp_data = r_rsp_data;
  assign rsp_ovf  = r_rsp_ovf;
  assign rsp_err  = r_rsp_err;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [WIDTH-1:0] r_acc;
    logic             r_sticky;
    logic             w_hit;

    assign w_hit = w_accept && w_chan_ok && (cmd_chan == CW'(k));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_acc <= '0;
      else if (w_hit) r_acc <= w_res;
    end

    // A new overflow outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              r_sticky <= 1'b0;
      else if (w_hit && w_ovf) r_sticky <= 1'b1;
      else if (clr_sticky[k])  r_sticky <= 1'b0;
    end

    assign count[k*WIDTH +: WIDTH] = r_acc;
    assign ovf_sticky[k]           = r_sticky;
  end

endmodule

`default_nettype wire

// File: tb/tb_param_step_acc.sv
// ============================================================================
// Module  : tb_param_step_acc
// Brief   : Scoreboard bench driving three param_step_acc configurations
//           (unsigned/4ch, signed/4ch, unsigned/3ch) with shared stimulus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_step_acc;

  typedef struct {
    logic [1:0] chan;
    logic [3:0] data;
    logic       ovf;
    logic       err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_chan = '0;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_arg = '0;
  logic       rsp_ready = 1'b0;
  logic [3:0] clr_sticky = '0;

  logic        cmd_ready_o [3];
  logic        rsp_valid_o [3];
  logic        rsp_ovf_o   [3];
  logic        rsp_err_o   [3];
  logic [1:0]  rsp_chan_o  [3];
  logic [3:0]  rsp_data_o  [3];
  logic [15:0] count_u, count_s;
  logic [11:0] count_c;
  logic [3:0]  sticky_u, sticky_s;
  logic [2:0]  sticky_c;

  int   cfg_signed [3] = '{0, 1, 0};
  int   cfg_ch     [3] = '{4, 4, 3};
  int   mdl_acc    [3][4];
  logic [3:0] mdl_sticky [3];
  bit   mdl_valid;
  rsp_t sb_q [3][$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  param_step_acc #(.WIDTH(4), .CHANNELS(4), .INC(1), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[0]),
    .cmd_chan(cmd_chan), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready), .rsp_chan(rsp_chan_o[0]),
    .rsp_data(rsp_data_o[0]), .rsp_ovf(rsp_ovf_o[0]), .rsp_err(rsp_err_o[0]),
    .count(count_u), .ovf_sticky(sticky_u), .clr_sticky(clr_sticky));

  param_step_acc #(.WIDTH(4), .CHANNELS(4), .INC(1), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[1]),
    .cmd_chan(cmd_chan), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready), .rsp_chan(rsp_chan_o[1]),
    .rsp_data(rsp_data_o[1]), .rsp_ovf(rsp_ovf_o[1]), .rsp_err(rsp_err_o[1]),
    .count(count_s), .ovf_sticky(sticky_s), .clr_sticky(clr_sticky));

  param_step_acc #(.WIDTH(4), .CHANNELS(3), .INC(1), .SIGNED(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[2]),
    .cmd_chan(cmd_chan), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid_o[2]), .rsp_ready(rsp_ready), .rsp_chan(rsp_chan_o[2]),
    .rsp_data(rsp_data_o[2]), .rsp_ovf(rsp_ovf_o[2]), .rsp_err(rsp_err_o[2]),
    .count(count_c), .ovf_sticky(sticky_c), .clr_sticky(clr_sticky[2:0]));

  task automatic check_val(string tag, int inst, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h at %0t", tag, inst, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs_count(int i);
    case (i)
      0:       return count_u;
      1:       return count_s;
      default: return {4'h0, count_c};
    endcase
  endfunction

  function automatic logic [3:0] obs_sticky(int i);
    case (i)
      0:       return sticky_u;
      1:       return sticky_s;
      default: return {1'b0, sticky_c};
    endcase
  endfunction

  function automatic logic [15:0] exp_count(int i);
    logic [15:0] v = '0;
    for (int k = 0; k < cfg_ch[i]; k++) v |= 16'(mdl_acc[i][k]) << (4 * k);
    return v;
  endfunction

  // Reference arithmetic in plain integers: exact sum, then range test
  function automatic void model_op(int i, logic [1:0] ch, logic [1:0] op, logic [3:0] arg,
                                   output rsp_t r);
    int a, step, sum, lo, hi, res;
    r.chan = ch; r.data = '0; r.ovf = 1'b0; r.err = 1'b0;
    if (int'(ch) >= cfg_ch[i]) begin
      r.err = 1'b1;
      return;
    end
    if (op == 2'b10) res = int'(arg);
    else if (op == 2'b11) res = 0;
    else begin
      a = mdl_acc[i][ch];
      if (cfg_signed[i] != 0 && a >= 8) a -= 16;
      step = (op == 2'b00) ? 1 : ((arg >= 4'd8) ? int'(arg) - 16 : int'(arg));
      sum  = a + step;
      lo   = (cfg_signed[i] != 0) ? -8 : 0;
      hi   = (cfg_signed[i] != 0) ? 7 : 15;
      res  = sum;
      if (sum > hi || sum < lo) begin
        r.ovf = 1'b1;
`ifdef PARAM_STEP_ACC_SAT_EN
        res = (sum > hi) ? hi : lo;
`endif
      end
    end
    r.data = 4'(res & 15);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) mdl_acc[i][k] = 0;
      mdl_sticky[i] = '0;
      sb_q[i].delete();
    end
    mdl_valid = 1'b0;
  endtask

  task automatic cycle(bit v, logic [1:0] ch, logic [1:0] op, logic [3:0] arg,
                       bit rdy, logic [3:0] clr);
    bit   acc;
    rsp_t r;
    @(negedge clk);
    cmd_valid = v; cmd_chan = ch; cmd_op = op; cmd_arg = arg;
    rsp_ready = rdy; clr_sticky = clr;
    #1;
    acc = v && (!mdl_valid || rdy);
    for (int i = 0; i < 3; i++) begin
      check_val("cmd_ready", i, 32'(cmd_ready_o[i]), 32'(!mdl_valid || rdy));
      check_val("rsp_valid", i, 32'(rsp_valid_o[i]), 32'(mdl_valid));
      if (mdl_valid) begin
        check_val("sb_nonempty", i, 32'(sb_q[i].size() != 0), 32'd1);
        if (sb_q[i].size() != 0) begin
          check_val("rsp_chan", i, 32'(rsp_chan_o[i]), 32'(sb_q[i][0].chan));
          check_val("rsp_data", i, 32'(rsp_data_o[i]), 32'(sb_q[i][0].data));
          check_val("rsp_ovf",  i, 32'(rsp_ovf_o[i]),  32'(sb_q[i][0].ovf));
          check_val("rsp_err",  i, 32'(rsp_err_o[i]),  32'(sb_q[i][0].err));
          if (rdy) void'(sb_q[i].pop_front());
        end
      end
      mdl_sticky[i] &= ~clr;
      if (acc) begin
        model_op(i, ch, op, arg, r);
        sb_q[i].push_back(r);
        if (!r.err) mdl_acc[i][ch] = int'(r.data);
        if (r.ovf) mdl_sticky[i][ch] = 1'b1;
      end
      if (cfg_ch[i] == 3) mdl_sticky[i][3] = 1'b0;
    end
    mdl_valid = acc || (mdl_valid && !rdy);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val("count",      i, 32'(obs_count(i)),  32'(exp_count(i)));
      check_val("ovf_sticky", i, 32'(obs_sticky(i)), 32'(mdl_sticky[i]));
    end
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 2'd0, 4'h0, 1'b1, 4'h0);
  endtask

  // Drop reset between edges and confirm the slot empties without a clock
  task automatic mid_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      check_val("rst_rsp_valid", i, 32'(rsp_valid_o[i]), 32'd0);
      check_val("rst_cmd_ready", i, 32'(cmd_ready_o[i]), 32'd1);
      check_val("rst_count",     i, 32'(obs_count(i)),   32'd0);
      check_val("rst_sticky",    i, 32'(obs_sticky(i)),  32'd0);
      check_val("rst_rsp_data",  i, 32'(rsp_data_o[i]),  32'd0);
      check_val("rst_rsp_flags", i, 32'({rsp_chan_o[i], rsp_ovf_o[i], rsp_err_o[i]}), 32'd0);
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    mid_reset();

    // increment chain on channel 0
    repeat (3) cycle(1'b1, 2'd0, 2'b00, 4'h0, 1'b1, 4'h0);
    idle();

    // unsigned overflow on channel 1, clear, then clear racing a new overflow
    cycle(1'b1, 2'd1, 2'b10, 4'hF, 1'b1, 4'h0);
    cycle(1'b1, 2'd1, 2'b00, 4'h0, 1'b1, 4'h0);
    cycle(1'b0, 2'd0, 2'b00, 4'h0, 1'b1, 4'h2);
    cycle(1'b1, 2'd1, 2'b10, 4'hF, 1'b1, 4'h0);
    cycle(1'b1, 2'd1, 2'b00, 4'h0, 1'b1, 4'h2);
    idle();

    // signed boundary cases on channel 0
    cycle(1'b1, 2'd0, 2'b10, 4'h7, 1'b1, 4'h0);
    cycle(1'b1, 2'd0, 2'b01, 4'h1, 1'b1, 4'h0);
    cycle(1'b1, 2'd0, 2'b10, 4'h9, 1'b1, 4'h0);
    cycle(1'b1, 2'd0, 2'b01, 4'hE, 1'b1, 4'h0);
    idle();

    // channel 3: out of range for the 3-channel instance
    cycle(1'b1, 2'd3, 2'b10, 4'h5, 1'b1, 4'h0);
    cycle(1'b1, 2'd3, 2'b11, 4'h0, 1'b1, 4'h0);
    idle();

    // backpressure: three stalled cycles, then the held command goes in
    cycle(1'b1, 2'd2, 2'b10, 4'h6, 1'b1, 4'h0);
    repeat (3) cycle(1'b1, 2'd2, 2'b00, 4'h0, 1'b0, 4'h0);
    cycle(1'b1, 2'd2, 2'b00, 4'h0, 1'b1, 4'h0);
    idle();

    // reset while a response is pending
    cycle(1'b1, 2'd2, 2'b10, 4'h6, 1'b1, 4'h0);
    cycle(1'b0, 2'd0, 2'b00, 4'h0, 1'b0, 4'h0);
    mid_reset();
    cycle(1'b1, 2'd2, 2'b00, 4'h0, 1'b1, 4'h0);
    idle();

    // random traffic
    for (int n = 0; n < 80; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
    end
    repeat (2) idle();
    for (int i = 0; i < 3; i++) check_val("sb_drained", i, 32'(sb_q[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
